// File: rtl/parser_pkg.sv
// Shared constants, rule entry layout and field-extract helper for the header parser.
package parser_pkg;

    localparam int HW_NUM     = 32;
    localparam int HEAD_W     = HW_NUM * 16;
    localparam int TYPE_NUM   = 2;
    localparam int KEY_NUM    = 4;
    localparam int RULE_NUM   = 8;
    localparam int META_SLOTS = 8;
    localparam int OFFSET_W   = 5;
    localparam int SHIFT_W    = 6;
    localparam int IDX_W      = $clog2(RULE_NUM);
    localparam int SLOT_W     = $clog2(META_SLOTS);
    // Each key offset entry is {valid, offset[4:0]}, key k at bits [6k+5:6k].
    localparam int KEYOFF_W   = OFFSET_W + 1;

    // Configuration word selects (addr[3:0]); 7..15 are reserved.
    localparam logic [3:0] CFG_VALID     = 4'd0;
    localparam logic [3:0] CFG_TYPE_DATA = 4'd1;
    localparam logic [3:0] CFG_TYPE_MASK = 4'd2;
    localparam logic [3:0] CFG_NEXT_OFF  = 4'd3;
    localparam logic [3:0] CFG_KEY_OFF   = 4'd4;
    localparam logic [3:0] CFG_META_IDX  = 4'd5;
    localparam logic [3:0] CFG_SHIFT     = 4'd6;

    // One rule entry. Multi-field vectors are packed LSB-first by field index.
    typedef struct packed {
        logic                         valid;
        logic [TYPE_NUM*16-1:0]       type_data;
        logic [TYPE_NUM*16-1:0]       type_mask;
        logic [TYPE_NUM*OFFSET_W-1:0] next_off;
        logic [KEY_NUM*KEYOFF_W-1:0]  key_off;
        logic [KEY_NUM*SLOT_W-1:0]    meta_idx;
        logic [SHIFT_W-1:0]           shift;
    } rule_t;

    // Halfword n of the header window; halfword 0 is the most significant.
    function automatic logic [15:0] get_hw(input logic [HEAD_W-1:0]   head,
                                           input logic [OFFSET_W-1:0] off);
        logic [HEAD_W-1:0] sh;
        sh = head << {off, 4'b0000};
        return sh[HEAD_W-1 -: 16];
    endfunction

endpackage

// File: rtl/parser_rule_table.sv
// Rule storage with 32-bit config write/readback and the parallel
// lowest-index-wins match against the extracted type fields.
module parser_rule_table
    import parser_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_rule_wren,
    input  logic                   i_rule_rden,
    input  logic [31:0]            i_rule_addr,
    input  logic [31:0]            i_rule_wdata,
    output logic                   o_rule_rdata_valid,
    output logic [31:0]            o_rule_rdata,
    input  logic [TYPE_NUM*16-1:0] i_type_fields,
    output logic                   o_hit,
    output logic [IDX_W-1:0]       o_idx,
    output rule_t                  o_rule
);

    rule_t                rules [RULE_NUM];
    logic [3:0]           addr_rule;
    logic [3:0]           addr_word;
    logic [IDX_W-1:0]     addr_idx;
    logic                 addr_in_range;
    logic [31:0]          rd_word;
    logic [RULE_NUM-1:0]  rule_match;
    logic                 unused_addr_bits;

    assign addr_rule        = i_rule_addr[7:4];
    assign addr_word        = i_rule_addr[3:0];
    assign addr_idx         = i_rule_addr[4 +: IDX_W];
    assign addr_in_range    = (addr_rule < 4'(RULE_NUM));
    assign unused_addr_bits = ^i_rule_addr[31:8];

    // Config write: only defined bits of each word are stored, out-of-range rules ignored.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int r = 0; r < RULE_NUM; r++) begin
                rules[r] <= '0;
            end
        end else if (i_rule_wren && addr_in_range) begin
            case (addr_word)
                CFG_VALID:     rules[addr_idx].valid     <= i_rule_wdata[0];
                CFG_TYPE_DATA: rules[addr_idx].type_data <= i_rule_wdata[TYPE_NUM*16-1:0];
                CFG_TYPE_MASK: rules[addr_idx].type_mask <= i_rule_wdata[TYPE_NUM*16-1:0];
                CFG_NEXT_OFF:  rules[addr_idx].next_off  <= i_rule_wdata[TYPE_NUM*OFFSET_W-1:0];
                CFG_KEY_OFF:   rules[addr_idx].key_off   <= i_rule_wdata[KEY_NUM*KEYOFF_W-1:0];
                CFG_META_IDX:  rules[addr_idx].meta_idx  <= i_rule_wdata[KEY_NUM*SLOT_W-1:0];
                CFG_SHIFT:     rules[addr_idx].shift     <= i_rule_wdata[SHIFT_W-1:0];
                default:       ;
            endcase
        end
    end

    // Readback mux: unused bits, reserved words and out-of-range rules read 0.
    always_comb begin
        rd_word = '0;
        if (addr_in_range) begin
            case (addr_word)
                CFG_VALID:     rd_word[0]                      = rules[addr_idx].valid;
                CFG_TYPE_DATA: rd_word[TYPE_NUM*16-1:0]        = rules[addr_idx].type_data;
                CFG_TYPE_MASK: rd_word[TYPE_NUM*16-1:0]        = rules[addr_idx].type_mask;
                CFG_NEXT_OFF:  rd_word[TYPE_NUM*OFFSET_W-1:0]  = rules[addr_idx].next_off;
                CFG_KEY_OFF:   rd_word[KEY_NUM*KEYOFF_W-1:0]   = rules[addr_idx].key_off;
                CFG_META_IDX:  rd_word[KEY_NUM*SLOT_W-1:0]     = rules[addr_idx].meta_idx;
                CFG_SHIFT:     rd_word[SHIFT_W-1:0]            = rules[addr_idx].shift;
                default:       rd_word = '0;
            endcase
        end
    end

    // Read data is registered from pre-write contents, so a same-cycle write returns the old value.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rule_rdata_valid <= 1'b0;
            o_rule_rdata       <= '0;
        end else begin
            o_rule_rdata_valid <= i_rule_rden;
            if (i_rule_rden) begin
                o_rule_rdata <= rd_word;
            end
        end
    end

    // Per-rule masked compare over all type fields at once.
    always_comb begin
        for (int r = 0; r < RULE_NUM; r++) begin
            rule_match[r] = rules[r].valid &&
                (((i_type_fields ^ rules[r].type_data) & rules[r].type_mask) == '0);
        end
    end

    // Priority encoder: scanning downward leaves the lowest matching index.
    always_comb begin
        o_hit  = 1'b0;
        o_idx  = '0;
        o_rule = '0;
        for (int r = RULE_NUM - 1; r >= 0; r--) begin
            if (rule_match[r]) begin
                o_hit  = 1'b1;
                o_idx  = IDX_W'(r);
                o_rule = rules[r];
            end
        end
    end

endmodule

// File: rtl/parser_layer.sv
// One parser layer: type-field match (S1), key extraction, metadata merge and
// header shift (S2). Metadata slot s is meta[16s+15:16s].
// Handshake: valid-only stream with no ready; a beat with i_valid high is always
// accepted and appears with o_valid high exactly two cycles later. Data outputs
// hold between beats and are meaningful only while o_valid is high.
// Parameters must match the parser_pkg constants, which fix the rule layout.
module parser_layer #(
    parameter int HW_NUM     = parser_pkg::HW_NUM,
    parameter int HEAD_W     = HW_NUM * 16,
    parameter int TYPE_NUM   = parser_pkg::TYPE_NUM,
    parameter int KEY_NUM    = parser_pkg::KEY_NUM,
    parameter int RULE_NUM   = parser_pkg::RULE_NUM,
    parameter int META_SLOTS = parser_pkg::META_SLOTS,
    parameter int META_W     = META_SLOTS * 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_rule_wren,
    input  logic                         i_rule_rden,
    input  logic [31:0]                  i_rule_addr,
    input  logic [31:0]                  i_rule_wdata,
    output logic                         o_rule_rdata_valid,
    output logic [31:0]                  o_rule_rdata,
    input  logic                         i_valid,
    input  logic [HEAD_W-1:0]            i_head,
    input  logic [META_W-1:0]            i_meta,
    input  logic [TYPE_NUM*5-1:0]        i_type_offset,
    output logic                         o_valid,
    output logic [HEAD_W-1:0]            o_head,
    output logic [META_W-1:0]            o_meta,
    output logic [TYPE_NUM*5-1:0]        o_type_offset,
    output logic                         o_hit,
    output logic [$clog2(RULE_NUM)-1:0]  o_rule_idx
);

    import parser_pkg::*;

    logic [TYPE_NUM*16-1:0]       type_fields;
    logic                         tbl_hit;
    logic [IDX_W-1:0]             tbl_idx;
    rule_t                        tbl_rule;

    logic                         s1_valid;
    logic [HEAD_W-1:0]            s1_head;
    logic [META_W-1:0]            s1_meta;
    logic                         s1_hit;
    logic [IDX_W-1:0]             s1_idx;
    rule_t                        s1_rule;

    logic [HEAD_W-1:0]            nxt_head;
    logic [META_W-1:0]            nxt_meta;
    logic [TYPE_NUM*OFFSET_W-1:0] nxt_toff;
    logic                         unused_rule_bits;

    // Match-only fields are not needed once the rule has been selected.
    assign unused_rule_bits = ^{s1_rule.valid, s1_rule.type_data, s1_rule.type_mask};

    // Pull each type field from the offset handed down by the previous layer.
    always_comb begin
        type_fields = '0;
        for (int t = 0; t < TYPE_NUM; t++) begin
            type_fields[16*t +: 16] = get_hw(i_head, i_type_offset[OFFSET_W*t +: OFFSET_W]);
        end
    end

    parser_rule_table u_rule_table (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_rule_wren        (i_rule_wren),
        .i_rule_rden        (i_rule_rden),
        .i_rule_addr        (i_rule_addr),
        .i_rule_wdata       (i_rule_wdata),
        .o_rule_rdata_valid (o_rule_rdata_valid),
        .o_rule_rdata       (o_rule_rdata),
        .i_type_fields      (type_fields),
        .o_hit              (tbl_hit),
        .o_idx              (tbl_idx),
        .o_rule             (tbl_rule)
    );

    // S1: capture the beat with its match result and a snapshot of the winning rule.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s1_head  <= '0;
            s1_meta  <= '0;
            s1_hit   <= 1'b0;
            s1_idx   <= '0;
            s1_rule  <= '0;
        end else begin
            s1_valid <= i_valid;
            if (i_valid) begin
                s1_head <= i_head;
                s1_meta <= i_meta;
                s1_hit  <= tbl_hit;
                s1_idx  <= tbl_idx;
                s1_rule <= tbl_rule;
            end
        end
    end

    // S2 datapath: keys read from the unshifted header, later keys overwrite earlier ones.
    always_comb begin
        nxt_head = s1_head;
        nxt_meta = s1_meta;
        nxt_toff = '0;
        if (s1_hit) begin
            for (int k = 0; k < KEY_NUM; k++) begin
                if (s1_rule.key_off[KEYOFF_W*k + OFFSET_W]) begin
                    nxt_meta[{s1_rule.meta_idx[SLOT_W*k +: SLOT_W], 4'b0000} +: 16] =
                        get_hw(s1_head, s1_rule.key_off[KEYOFF_W*k +: OFFSET_W]);
                end
            end
            if (s1_rule.shift >= SHIFT_W'(HW_NUM)) begin
                nxt_head = '0;
            end else begin
                nxt_head = s1_head << {s1_rule.shift, 4'b0000};
            end
            nxt_toff = s1_rule.next_off;
        end
    end

    // S2 output registers: update only on a valid beat, otherwise hold.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid       <= 1'b0;
            o_head        <= '0;
            o_meta        <= '0;
            o_type_offset <= '0;
            o_hit         <= 1'b0;
            o_rule_idx    <= '0;
        end else begin
            o_valid <= s1_valid;
            if (s1_valid) begin
                o_head        <= nxt_head;
                o_meta        <= nxt_meta;
                o_type_offset <= nxt_toff;
                o_hit         <= s1_hit;
                o_rule_idx    <= s1_hit ? s1_idx : '0;
            end
        end
    end

endmodule

// File: tb/tb_parser_layer.sv
// Directed bench for parser_layer: match, priority, miss, shift bounds,
// config readback, back-to-back with a mid-stream rule rewrite, reset flush.
`timescale 1ns/1ps
module tb_parser_layer;

    localparam int HEAD_W = 512;
    localparam int META_W = 128;
    localparam logic [META_W-1:0] M0 = 128'h8888_7777_6666_5555_4444_3333_2222_1111;
    localparam logic [META_W-1:0] M1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              i_rule_wren;
    logic              i_rule_rden;
    logic [31:0]       i_rule_addr;
    logic [31:0]       i_rule_wdata;
    logic              o_rule_rdata_valid;
    logic [31:0]       o_rule_rdata;
    logic              i_valid;
    logic [HEAD_W-1:0] i_head;
    logic [META_W-1:0] i_meta;
    logic [9:0]        i_type_offset;
    logic              o_valid;
    logic [HEAD_W-1:0] o_head;
    logic [META_W-1:0] o_meta;
    logic [9:0]        o_type_offset;
    logic              o_hit;
    logic [2:0]        o_rule_idx;

    int checks = 0;
    int errors = 0;

    parser_layer dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_rule_wren        (i_rule_wren),
        .i_rule_rden        (i_rule_rden),
        .i_rule_addr        (i_rule_addr),
        .i_rule_wdata       (i_rule_wdata),
        .o_rule_rdata_valid (o_rule_rdata_valid),
        .o_rule_rdata       (o_rule_rdata),
        .i_valid            (i_valid),
        .i_head             (i_head),
        .i_meta             (i_meta),
        .i_type_offset      (i_type_offset),
        .o_valid            (o_valid),
        .o_head             (o_head),
        .o_meta             (o_meta),
        .o_type_offset      (o_type_offset),
        .o_hit              (o_hit),
        .o_rule_idx         (o_rule_idx)
    );

    // ---------------- clock ----------------
    always #5 i_clk = ~i_clk;

    // ---------------- helpers ----------------
    function automatic logic [HEAD_W-1:0] hw_put(input logic [HEAD_W-1:0] h, input int n,
                                                 input logic [15:0] v);
        logic [HEAD_W-1:0] r;
        r = h;
        r[HEAD_W-1-16*n -: 16] = v;
        return r;
    endfunction

    function automatic logic [META_W-1:0] meta_put(input logic [META_W-1:0] m, input int s,
                                                   input logic [15:0] v);
        logic [META_W-1:0] r;
        r = m;
        r[16*s +: 16] = v;
        return r;
    endfunction

    // Halfword n = base + n for all 32 halfwords.
    function automatic logic [HEAD_W-1:0] ramp_head(input logic [15:0] base);
        logic [HEAD_W-1:0] h;
        h = '0;
        for (int n = 0; n < 32; n++) h = hw_put(h, n, base + 16'(n));
        return h;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic cfg_write(input int rule, input int word, input logic [31:0] data);
        @(posedge i_clk); #1;
        i_rule_wren  = 1'b1;
        i_rule_addr  = 32'(rule * 16 + word);
        i_rule_wdata = data;
        @(posedge i_clk); #1;
        i_rule_wren  = 1'b0;
        i_rule_addr  = '0;
        i_rule_wdata = '0;
    endtask

    task automatic cfg_read(input int rule, input int word, output logic vld,
                            output logic [31:0] data);
        @(posedge i_clk); #1;
        i_rule_rden = 1'b1;
        i_rule_addr = 32'(rule * 16 + word);
        @(posedge i_clk); #1;
        i_rule_rden = 1'b0;
        i_rule_addr = '0;
        vld  = o_rule_rdata_valid;
        data = o_rule_rdata;
    endtask

    // Sends one beat and returns the number of cycles until o_valid (-1 on timeout).
    task automatic run_beat(input logic [HEAD_W-1:0] h, input logic [META_W-1:0] m,
                            input logic [9:0] toff, output int lat);
        @(posedge i_clk); #1;
        i_valid = 1'b1;
        i_head = h;
        i_meta = m;
        i_type_offset = toff;
        lat = -1;
        for (int n = 1; n <= 8; n++) begin
            @(posedge i_clk); #1;
            i_valid = 1'b0;
            if (o_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        i_rst = 1'b1;
        i_rule_wren = 0; i_rule_rden = 0; i_rule_addr = '0; i_rule_wdata = '0;
        i_valid = 0; i_head = '0; i_meta = '0; i_type_offset = '0;
        repeat (3) @(posedge i_clk);
        #1;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid: got %0b want 0", o_valid); end
        checks++; if (o_head !== '0) begin errors++; $display("FAIL reset_o_head: got %h want 0", o_head); end
        checks++; if (o_meta !== '0) begin errors++; $display("FAIL reset_o_meta: got %h want 0", o_meta); end
        checks++; if ({o_hit, o_rule_idx, o_type_offset} !== 14'd0) begin errors++; $display("FAIL reset_hit_idx_toff: got %0b %0d %h want 0 0 0", o_hit, o_rule_idx, o_type_offset); end
        checks++; if ({o_rule_rdata_valid, o_rule_rdata} !== 33'd0) begin errors++; $display("FAIL reset_rdata: got %0b %h want 0 0", o_rule_rdata_valid, o_rule_rdata); end
        i_rst = 1'b0;
    endtask

    task automatic test_basic_hit();
        logic [HEAD_W-1:0] h, eh;
        int lat;
        cfg_write(0, 1, 32'h0000_0800);
        cfg_write(0, 2, 32'h0000_FFFF);
        cfg_write(0, 3, 32'h0000_0069);   // next offsets: type0=9, type1=3
        cfg_write(0, 4, 32'h0000_0026);   // key0 valid, offset 6
        cfg_write(0, 5, 32'h0000_0002);   // key0 -> slot 2
        cfg_write(0, 6, 32'h0000_0007);
        cfg_write(0, 0, 32'h0000_0001);
        h = hw_put(ramp_head(16'hA000), 6, 16'h0800);
        eh = '0;
        for (int n = 0; n < 25; n++) eh = hw_put(eh, n, 16'hA000 + 16'(n + 7));
        run_beat(h, M0, 10'd6, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL basic_latency: got %0d want 2", lat); end
        checks++; if (o_hit !== 1'b1) begin errors++; $display("FAIL basic_hit: got %0b want 1", o_hit); end
        checks++; if (o_rule_idx !== 3'd0) begin errors++; $display("FAIL basic_idx: got %0d want 0", o_rule_idx); end
        checks++; if (o_meta !== 128'h8888_7777_6666_5555_4444_0800_2222_1111) begin errors++; $display("FAIL basic_meta: got %h", o_meta); end
        checks++; if (o_head !== eh) begin errors++; $display("FAIL basic_head: got %h want %h", o_head, eh); end
        checks++; if (o_type_offset !== 10'h069) begin errors++; $display("FAIL basic_toff: got %h want 069", o_type_offset); end
        @(posedge i_clk); #1;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL basic_single_pulse: got %0b want 0", o_valid); end
    endtask

    task automatic test_priority();
        logic [HEAD_W-1:0] h, eh;
        int lat;
        cfg_write(1, 1, 32'h0000_86DD);
        cfg_write(1, 2, 32'h0000_FFFF);
        cfg_write(1, 6, 32'h0000_0001);
        cfg_write(1, 0, 32'h0000_0001);
        cfg_write(3, 1, 32'h0000_86DD);
        cfg_write(3, 2, 32'h0000_FFFF);
        cfg_write(3, 3, 32'h0000_001F);
        cfg_write(3, 4, 32'h0000_08A1);   // key0 off 1, key1 off 2, both valid
        cfg_write(3, 5, 32'h0000_002D);   // both keys -> slot 5
        cfg_write(3, 6, 32'h0000_0002);
        cfg_write(3, 0, 32'h0000_0001);
        h = hw_put(ramp_head(16'hB000), 6, 16'h86DD);
        run_beat(h, M0, 10'd6, lat);
        eh = '0;
        for (int n = 0; n < 31; n++) eh = hw_put(eh, n, (n == 5) ? 16'h86DD : 16'hB000 + 16'(n + 1));
        checks++; if (lat !== 2 || o_hit !== 1'b1 || o_rule_idx !== 3'd1) begin errors++; $display("FAIL prio_low_idx: lat %0d hit %0b idx %0d want 2 1 1", lat, o_hit, o_rule_idx); end
        checks++; if (o_head !== eh) begin errors++; $display("FAIL prio_head_r1: got %h want %h", o_head, eh); end
        checks++; if (o_meta !== M0) begin errors++; $display("FAIL prio_meta_r1: got %h want %h", o_meta, M0); end
        cfg_write(1, 0, 32'h0);
        run_beat(h, M0, 10'd6, lat);
        eh = '0;
        for (int n = 0; n < 30; n++) eh = hw_put(eh, n, (n == 4) ? 16'h86DD : 16'hB000 + 16'(n + 2));
        checks++; if (lat !== 2 || o_hit !== 1'b1 || o_rule_idx !== 3'd3) begin errors++; $display("FAIL prio_after_clear: lat %0d hit %0b idx %0d want 2 1 3", lat, o_hit, o_rule_idx); end
        checks++; if (o_meta !== 128'h8888_7777_B002_5555_4444_3333_2222_1111) begin errors++; $display("FAIL prio_key_collision: got %h", o_meta); end
        checks++; if (o_head !== eh) begin errors++; $display("FAIL prio_head_r3: got %h want %h", o_head, eh); end
        checks++; if (o_type_offset !== 10'h01F) begin errors++; $display("FAIL prio_toff: got %h want 01f", o_type_offset); end
    endtask

    task automatic test_miss();
        logic [HEAD_W-1:0] h;
        int lat;
        h = hw_put(ramp_head(16'hE000), 6, 16'h0801);
        run_beat(h, M1, 10'd6, lat);
        checks++; if (lat !== 2 || o_hit !== 1'b0 || o_rule_idx !== 3'd0) begin errors++; $display("FAIL miss_hit_idx: lat %0d hit %0b idx %0d want 2 0 0", lat, o_hit, o_rule_idx); end
        checks++; if (o_head !== h) begin errors++; $display("FAIL miss_head: got %h want %h", o_head, h); end
        checks++; if (o_meta !== M1) begin errors++; $display("FAIL miss_meta: got %h want %h", o_meta, M1); end
        checks++; if (o_type_offset !== 10'd0) begin errors++; $display("FAIL miss_toff: got %h want 0", o_type_offset); end
    endtask

    task automatic test_shift_bounds();
        logic [HEAD_W-1:0] h;
        int lat;
        h = hw_put(ramp_head(16'hB000), 6, 16'h86DD);
        cfg_write(3, 6, 32'd32);
        run_beat(h, M0, 10'd6, lat);
        checks++; if (lat !== 2 || o_head !== '0) begin errors++; $display("FAIL shift_32: lat %0d head %h want 2 0", lat, o_head); end
        cfg_write(3, 6, 32'd31);
        run_beat(h, M0, 10'd6, lat);
        checks++; if (o_head !== hw_put('0, 0, 16'hB01F)) begin errors++; $display("FAIL shift_31: got %h", o_head); end
        cfg_write(3, 6, 32'd63);
        run_beat(h, M0, 10'd6, lat);
        checks++; if (o_head !== '0) begin errors++; $display("FAIL shift_63: got %h want 0", o_head); end
    endtask

    task automatic test_config_readback();
        logic [31:0] exp_rd [16];
        logic        vld;
        logic [31:0] d;
        exp_rd = '{32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h3FF, 32'hFF_FFFF, 32'hFFF, 32'h3F,
                   32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        for (int w = 0; w < 16; w++) cfg_write(4, w, 32'hFFFF_FFFF);
        for (int w = 0; w < 16; w++) begin
            cfg_read(4, w, vld, d);
            checks++; if (vld !== 1'b1 || d !== exp_rd[w]) begin errors++; $display("FAIL rd_word%0d: valid %0b data %h want 1 %h", w, vld, d, exp_rd[w]); end
        end
        @(posedge i_clk); #1;
        checks++; if (o_rule_rdata_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_drop: got %0b want 0", o_rule_rdata_valid); end
        cfg_write(9, 1, 32'hFFFF_FFFF);
        cfg_read(9, 1, vld, d);
        checks++; if (vld !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL rd_rule9: valid %0b data %h want 1 0", vld, d); end
        cfg_read(1, 1, vld, d);
        checks++; if (d !== 32'h0000_86DD) begin errors++; $display("FAIL wr_rule9_alias: rule1 data %h want 86dd", d); end
        // Same-cycle write and read of one word returns the previous contents.
        @(posedge i_clk); #1;
        i_rule_wren = 1'b1; i_rule_rden = 1'b1;
        i_rule_addr = 32'(4 * 16 + 6); i_rule_wdata = 32'h5;
        @(posedge i_clk); #1;
        i_rule_wren = 1'b0; i_rule_rden = 1'b0; i_rule_addr = '0; i_rule_wdata = '0;
        checks++; if (o_rule_rdata_valid !== 1'b1 || o_rule_rdata !== 32'h3F) begin errors++; $display("FAIL rw_same_cycle: valid %0b data %h want 1 3f", o_rule_rdata_valid, o_rule_rdata); end
        cfg_read(4, 6, vld, d);
        checks++; if (d !== 32'h5) begin errors++; $display("FAIL rw_after: got %h want 5", d); end
    endtask

    task automatic test_back_to_back();
        logic [HEAD_W-1:0] got_head [10];
        logic [META_W-1:0] got_meta [10];
        logic [3:0]        got_hi   [10];
        logic [HEAD_W-1:0] eh;
        int got;
        cfg_write(5, 1, 32'h0000_1234);
        cfg_write(5, 2, 32'h0000_FFFF);
        cfg_write(5, 4, 32'h0000_002A);   // key0 valid, offset 10
        cfg_write(5, 5, 32'h0);
        cfg_write(5, 6, 32'h0);
        cfg_write(5, 0, 32'h1);
        got = 0;
        fork
            begin
                for (int c = 0; c < 10; c++) begin
                    @(posedge i_clk); #1;
                    i_valid = 1'b1;
                    i_head = hw_put(hw_put(hw_put(hw_put('0, 0, 16'hC000 + 16'(c)), 1, 16'hD000 + 16'(c)),
                                    6, 16'h1234), 10, 16'h0100 + 16'(c));
                    i_meta = M0;
                    i_type_offset = 10'd6;
                    i_rule_wren  = (c == 4);
                    i_rule_addr  = (c == 4) ? 32'(5 * 16 + 6) : 32'h0;
                    i_rule_wdata = (c == 4) ? 32'h1 : 32'h0;
                end
                @(posedge i_clk); #1;
                i_valid = 1'b0;
                i_rule_wren = 1'b0;
            end
            begin
                for (int n = 0; n < 16; n++) begin
                    @(posedge i_clk); #1;
                    if (o_valid) begin
                        if (got < 10) begin
                            got_head[got] = o_head;
                            got_meta[got] = o_meta;
                            got_hi[got]   = {o_hit, o_rule_idx};
                        end
                        got++;
                    end
                end
            end
        join
        checks++; if (got !== 10) begin errors++; $display("FAIL b2b_count: got %0d pulses want 10", got); end
        for (int i = 0; i < 10 && i < got; i++) begin
            if (i < 5)
                eh = hw_put(hw_put(hw_put(hw_put('0, 0, 16'hC000 + 16'(i)), 1, 16'hD000 + 16'(i)),
                            6, 16'h1234), 10, 16'h0100 + 16'(i));
            else
                eh = hw_put(hw_put(hw_put('0, 0, 16'hD000 + 16'(i)), 5, 16'h1234), 9, 16'h0100 + 16'(i));
            checks++; if (got_head[i] !== eh) begin errors++; $display("FAIL b2b_head beat %0d: got %h want %h", i, got_head[i], eh); end
            checks++; if (got_meta[i] !== meta_put(M0, 0, 16'h0100 + 16'(i)) || got_hi[i] !== 4'hD) begin errors++; $display("FAIL b2b_meta_idx beat %0d: meta %h hit/idx %h want hit 1 idx 5", i, got_meta[i], got_hi[i]); end
        end
    endtask

    task automatic test_reset_flush();
        logic [HEAD_W-1:0] ha, hb;
        logic        vld;
        logic [31:0] d;
        int pulses, lat;
        ha = hw_put(ramp_head(16'hA000), 6, 16'h0800);
        hb = hw_put(ramp_head(16'h9000), 6, 16'h0800);
        @(posedge i_clk); #1;
        i_valid = 1'b1; i_head = ha; i_meta = M0; i_type_offset = 10'd6;
        @(posedge i_clk); #1;
        i_head = hb;
        #2;
        i_rst = 1'b1;
        #1;
        checks++; if (o_valid !== 1'b0 || o_hit !== 1'b0 || o_rule_idx !== 3'd0 || o_type_offset !== 10'd0) begin errors++; $display("FAIL flush_ctrl_outputs: valid %0b hit %0b idx %0d toff %h want all 0", o_valid, o_hit, o_rule_idx, o_type_offset); end
        checks++; if (o_head !== '0 || o_meta !== '0) begin errors++; $display("FAIL flush_data_outputs: head %h meta %h want 0", o_head, o_meta); end
        checks++; if (o_rule_rdata !== 32'h0 || o_rule_rdata_valid !== 1'b0) begin errors++; $display("FAIL flush_rdata: valid %0b data %h want 0 0", o_rule_rdata_valid, o_rule_rdata); end
        i_valid = 1'b0;
        pulses = 0;
        for (int n = 0; n < 6; n++) begin
            @(posedge i_clk); #1;
            if (n == 2) i_rst = 1'b0;
            if (o_valid) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL flush_no_pulse: got %0d pulses want 0", pulses); end
        cfg_read(0, 1, vld, d);
        checks++; if (vld !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL flush_rule_cleared: valid %0b data %h want 1 0", vld, d); end
        run_beat(ha, M0, 10'd6, lat);
        checks++; if (lat !== 2 || o_hit !== 1'b0 || o_head !== ha || o_meta !== M0) begin errors++; $display("FAIL flush_post_miss: lat %0d hit %0b want 2 0 with passthrough", lat, o_hit); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic_hit();
        test_priority();
        test_miss();
        test_shift_bounds();
        test_config_readback();
        test_back_to_back();
        test_reset_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
